// File: rtl/pipe_add.sv
// pipe_add -- pipelined WIDTH-bit adder with valid/ready handshakes.
//
// The add is split into NSTAGE = WIDTH/CHUNK ripple chunks. Each stage
// adds one chunk and registers the partial sum, the chunk carry and a copy
// of the operands. The final stage drives the outputs directly. Stalls are
// global: every stage holds while the output is valid and not accepted.
//
// Optional feature macro: PIPE_ADD_SUB_EN. When it is defined, the block
// gains a `sub` input and computes a + ~b + 1 for sub=1.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand set valid
//   in_ready   block can accept an operand set this cycle
//   a, b       operands (WIDTH bits)
//   c_in       carry in (ignored when sub=1)
//   sub        subtract select (only with PIPE_ADD_SUB_EN)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        a + b + c_in modulo 2^WIDTH
//   c_out      carry out of the MSB
//   ovf        two's-complement overflow (carry into MSB ^ carry out of MSB)
module pipe_add #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef PIPE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / CHUNK;

  if ((WIDTH < CHUNK) || (WIDTH % CHUNK != 0)) begin : g_cfg_check
    $error("pipe_add: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // Subtraction is folded in before stage 1: inverting b and forcing the
  // carry in lets the same adder chain compute a - b, and the inverted
  // operand travels down the pipeline with the rest of the operand set.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
`ifdef PIPE_ADD_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | c_in;
`else
  assign b_eff   = b;
  assign cin_eff = c_in;
`endif

  // Global stall: the pipeline moves only when the output slot is free or
  // being drained this cycle.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !reset;

  // Per-stage registers; element k belongs to pipeline stage k+1.
  logic             vld_q [NSTAGE];
  logic [WIDTH-1:0] sum_q [NSTAGE];
  logic             cy_q  [NSTAGE];
  logic [WIDTH-1:0] a_q   [NSTAGE];
  logic [WIDTH-1:0] b_q   [NSTAGE];
  logic             ovf_q;

  genvar gi;
  for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
    logic             vld_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic             cy_in;
    logic [CHUNK-1:0] chunk_d;
    logic             cy_d;
    logic [WIDTH-1:0] sum_d;

    if (gi == 0) begin : g_src
      assign vld_in = in_valid;
      assign a_in   = a;
      assign b_in   = b_eff;
      assign sum_in = '0;
      assign cy_in  = cin_eff;
    end else begin : g_src
      assign vld_in = vld_q[gi-1];
      assign a_in   = a_q[gi-1];
      assign b_in   = b_q[gi-1];
      assign sum_in = sum_q[gi-1];
      assign cy_in  = cy_q[gi-1];
    end

    assign {cy_d, chunk_d} = {1'b0, a_in[gi*CHUNK +: CHUNK]}
                           + {1'b0, b_in[gi*CHUNK +: CHUNK]}
                           + {{CHUNK{1'b0}}, cy_in};

    // Lower sum bits pass through; this stage fills in only its own chunk.
    always_comb begin
      sum_d                    = sum_in;
      sum_d[gi*CHUNK +: CHUNK] = chunk_d;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        vld_q[gi] <= 1'b0;
        sum_q[gi] <= '0;
        cy_q[gi]  <= 1'b0;
        a_q[gi]   <= '0;
        b_q[gi]   <= '0;
      end else if (advance) begin
        vld_q[gi] <= vld_in;
        sum_q[gi] <= sum_d;
        cy_q[gi]  <= cy_d;
        a_q[gi]   <= a_in;
        b_q[gi]   <= b_in;
      end
    end

    if (gi == NSTAGE - 1) begin : g_flag
      // Carry into the MSB is recovered from the MSB sum bit and its operand
      // bits, so no extra carry tap inside the chunk adder is needed.
      logic msb_cin;
      assign msb_cin = sum_d[WIDTH-1] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1];

      always_ff @(posedge clock) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= msb_cin ^ cy_d;
        end
      end
    end
  end

  assign out_valid = vld_q[NSTAGE-1];
  assign sum       = sum_q[NSTAGE-1];
  assign c_out     = cy_q[NSTAGE-1];
  assign ovf       = ovf_q;

endmodule
